div16_seq: RTL and testbench
============================

DIV16_SEQ -- requirements
Module: div16_seq

Interface
REQ-001 SHALL have parameter: WIDTH, default 16, operand/result width in bits; SHALL be a multiple of 4.
REQ-002 SHALL have ports, clock and reset first:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a division; sampled only in IDLE.
- dividend  input  WIDTH  numerator; sampled when start is accepted.
- divisor  input  WIDTH  denominator; sampled when start is accepted.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when results become valid.
- quotient  output  WIDTH  unsigned quotient; registered.
- remainder  output  WIDTH  unsigned remainder; registered.
- div_by_zero  output  1  high with done when divisor was 0; held until next accepted start.
REQ-003 SHALL use exactly one clock (clk) and one asynchronous active-low reset (rst_n).

Function
REQ-004 SHALL perform unsigned restoring division: dividend = quotient*divisor + remainder, with remainder < divisor.
REQ-005 SHALL implement states IDLE, CALC and DONE, encoded as 2 bits.
REQ-006 In IDLE, start=1 at edge E0 SHALL be accepted: capture operands, clear the iteration counter, set busy=1, clear div_by_zero, and go to CALC.
REQ-007 If the captured divisor is 0, the block SHALL skip CALC and go to DONE at E1.
REQ-008 On a divide-by-zero, it SHALL load quotient=all ones, remainder=dividend and div_by_zero=1.
REQ-009 In CALC, each edge SHALL perform one iteration:
- shift {partial remainder, dividend} left by 1;
- compute trial = partial remainder − divisor;
- if trial has no borrow (≥0), keep trial and set the quotient LSB to 1;
- otherwise restore the partial remainder and set the quotient LSB to 0.
REQ-010 Subtraction SHALL be done as partial + ~divisor + 1 through the carry-lookahead adder; carry-out=1 SHALL mean no borrow.
REQ-011 The partial remainder SHALL be WIDTH+1 bits internally so that no intermediate value overflows.
REQ-012 CALC SHALL run exactly WIDTH iterations, at edges E1..E16 for WIDTH=16, then go to DONE.
REQ-013 In DONE, quotient and remainder SHALL be loaded, done SHALL be 1 for exactly one cycle, busy SHALL be 0, and the next edge SHALL return to IDLE.
REQ-014 Latency from start acceptance to the done cycle SHALL be WIDTH+1 cycles, or 2 cycles for divide-by-zero.
REQ-015 quotient, remainder and div_by_zero SHALL hold their last values until the next accepted start.
REQ-016 start while busy=1 or in DONE SHALL be ignored, with no effect on the operation in progress.
REQ-017 start held high continuously SHALL give back-to-back operations, each accepted in IDLE.
REQ-018 A change on dividend or divisor after acceptance SHALL NOT affect the result.

Reset
REQ-019 When rst_n=0, the block SHALL immediately go to IDLE and set busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and clear the counter and working registers.
REQ-020 Reset asserted during CALC SHALL abort the operation with no done pulse; the first start after reset release SHALL be processed normally.

Structure
REQ-021 State encodings and the default WIDTH SHALL be defined in a shared package, div_pkg.
REQ-022 The subtractor SHALL be one sub-module: a WIDTH+1-bit carry-lookahead adder named cla_addsub, built from the team's 4-bit lookahead groups with a ripple of group carries.
REQ-023 There SHALL be no other sub-modules; the FSM, counter and shift registers SHALL live in div16_seq.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- dividend=100, divisor=7, start at E0 -> done at E17, quotient=14, remainder=2, div_by_zero=0.
- dividend=0xFFFF, divisor=1 -> quotient=0xFFFF, remainder=0x0000 after 17 cycles.
- dividend=3, divisor=10 -> quotient=0, remainder=3.
- dividend=5, divisor=0 -> done at E2, div_by_zero=1, quotient=0xFFFF, remainder=5.
- Start 0xFFFF/0xFFFF, pulse rst_n low at E8 -> busy=0, no done, outputs 0; then 9/4 -> quotient=2, remainder=1.
- Start 50/5, then assert start with 7/7 at E5 -> the second start is ignored; done at E17 with quotient=10, remainder=0.
REQ-025 The bench SHALL also run at least 1000 random operand pairs checked against the relation in REQ-004.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM encoding, default width,
// and the group-count helper used by the lookahead adder.
package div_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned GroupW   = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  // Number of 4-bit lookahead groups needed to cover w bits.
  function automatic int unsigned num_groups(input int unsigned w);
    return (w + GroupW - 1) / GroupW;
  endfunction

endpackage

// File: rtl/cla_addsub.sv
// Carry-lookahead adder/subtractor. 4-bit lookahead groups, group carries ripple.
// With sub_i=1 it computes a - b as a + ~b + 1; cout_o=1 then means no borrow.
module cla_addsub
  import div_pkg::*;
#(
  parameter int unsigned Width = 17
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             sub_i,
  output logic [Width-1:0] sum_o,
  output logic             cout_o
);

  localparam int unsigned NumGroups = num_groups(Width);
  localparam int unsigned PadW      = NumGroups * GroupW;

  logic [PadW-1:0] a_pad;
  logic [PadW-1:0] b_pad;
  logic [PadW-1:0] g;
  logic [PadW-1:0] p;
  logic [PadW:0]   c;
  logic            grp_g;
  logic            grp_p;

  // Per-group lookahead carries; each group's carry-out feeds the next group.
  always_comb begin
    a_pad = PadW'(a_i);
    b_pad = PadW'(sub_i ? ~b_i : b_i);
    g     = a_pad & b_pad;
    p     = a_pad ^ b_pad;
    c     = '0;
    c[0]  = sub_i;
    grp_g = 1'b0;
    grp_p = 1'b0;
    for (int k = 0; k < int'(NumGroups); k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      grp_g    = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p    = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
      c[4*k+4] = grp_g | (grp_p & c[4*k]);
    end
  end

  assign sum_o  = p[Width-1:0] ^ c[Width-1:0];
  assign cout_o = c[Width];

  // Carries above the true MSB exist only because of group padding.
  if (PadW > Width) begin : g_pad
    logic unused_carry;
    assign unused_carry = ^c[PadW:Width+1];
  end

endmodule

// File: rtl/div16_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// WIDTH must be a multiple of 4.
module div16_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [WIDTH:0]  rem_q;    // partial remainder, one bit wider than operands
  logic [WIDTH-1:0] dvd_q;   // dividend shifts out, quotient bits shift in
  logic [WIDTH-1:0] dsr_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             no_borrow;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] dvd_d;

  cla_addsub #(
    .Width (WIDTH + 1)
  ) u_sub (
    .a_i    (shifted),
    .b_i    ({1'b0, dsr_q}),
    .sub_i  (1'b1),
    .sum_o  (trial),
    .cout_o (no_borrow)
  );

  // One restoring step: shift, trial-subtract, keep or restore.
  always_comb begin
    shifted = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    rem_d   = no_borrow ? trial : shifted;
    dvd_d   = {dvd_q[WIDTH-2:0], no_borrow};
  end

  // The stored remainder is always below the divisor, so its MSB stays clear.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_q[WIDTH];

  // Control FSM, iteration counter, working registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            dvd_q       <= dividend;
            dsr_q       <= divisor;
            rem_q       <= '0;
            cnt_q       <= '0;
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            state_q     <= StCalc;
          end
        end
        StCalc: begin
          if (dsr_q == '0) begin
            state_q <= StDone;
          end else begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntW'(WIDTH - 1)) begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          // Divide-by-zero leaves dvd_q untouched, so it still holds the dividend.
          if (dsr_q == '0) begin
            quotient    <= '1;
            remainder   <= dvd_q;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= dvd_q;
            remainder   <= rem_q[WIDTH-1:0];
          end
          busy    <= 1'b0;
          done    <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_div16_seq.sv
// Directed and random bench for div16_seq with a queue-based scoreboard.
module tb_div16_seq;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   t0 = 0;

  div16_seq #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    sb.push_back(e);
  endtask

  // Drives a request so that the next rising edge is the accept edge E0.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (push) push_exp(a, b);
    tick();
    start = 1'b0;
    t0    = cyc;
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Waits (bounded) for done, checks latency, pops and compares the scoreboard.
  task automatic wait_done(input int lat, input string tag);
    exp_t e;
    while (done !== 1'b1 && (cyc - t0) < 40) tick();
    check({tag, "_latency"}, 32'(cyc - t0), 32'(lat));
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_quotient"}, 32'(quotient), 32'(e.q));
      check({tag, "_remainder"}, 32'(remainder), 32'(e.r));
      check({tag, "_dz"}, 32'(div_by_zero), 32'(e.dz));
    end
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           seen;

    // Reset state
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dz", 32'(div_by_zero), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // 100 / 7
    start_op(16'd100, 16'd7, 1'b1);
    wait_done(17, "s1");
    check("s1_q_const", 32'(quotient), 32'd14);
    check("s1_r_const", 32'(remainder), 32'd2);

    // 0xFFFF / 1
    start_op(16'hFFFF, 16'd1, 1'b1);
    wait_done(17, "s2");

    // 3 / 10
    start_op(16'd3, 16'd10, 1'b1);
    wait_done(17, "s3");

    // 5 / 0
    start_op(16'd5, 16'd0, 1'b1);
    wait_done(2, "s4");
    check("s4_dz_const", 32'(div_by_zero), 32'd1);
    check("s4_dz_held", 32'(div_by_zero), 32'd1);

    // Reset in the middle of a division
    start_op(16'hFFFF, 16'hFFFF, 1'b0);
    repeat (8) tick();
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_dz", 32'(div_by_zero), 32'd0);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      tick();
      if (done === 1'b1) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    start_op(16'd9, 16'd4, 1'b1);
    wait_done(17, "s5");
    check("s5_q_const", 32'(quotient), 32'd2);
    check("s5_r_const", 32'(remainder), 32'd1);

    // Start during CALC is ignored; operand changes after accept are ignored
    start_op(16'd50, 16'd5, 1'b1);
    repeat (4) tick();
    start    = 1'b1;
    dividend = 16'd7;
    divisor  = 16'd7;
    tick();
    start    = 1'b0;
    dividend = 16'd123;
    divisor  = 16'd0;
    check("s6_busy_mid", 32'(busy), 32'd1);
    wait_done(17, "s6");
    check("s6_q_const", 32'(quotient), 32'd10);
    check("s6_r_const", 32'(remainder), 32'd0);

    // start held high: back-to-back operations
    dividend = 16'd20;
    divisor  = 16'd3;
    start    = 1'b1;
    push_exp(16'd20, 16'd3);
    push_exp(16'd20, 16'd3);
    tick();
    t0 = cyc;
    while (done !== 1'b1 && (cyc - t0) < 40) tick();
    check("b2b_first_latency", 32'(cyc - t0), 32'd17);
    if (sb.size() > 0) void'(sb.pop_front());
    check("b2b_first_quotient", 32'(quotient), 32'd6);
    tick();
    start = 1'b0;
    t0    = cyc;
    check("b2b_second_busy", 32'(busy), 32'd1);
    wait_done(17, "b2b2");

    // Random operand pairs
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 1) == 0) b = 16'($urandom_range(1, 65535));
      else b = 16'($urandom_range(1, 300));
      start_op(a, b, 1'b1);
      wait_done(17, "rnd");
      check("rnd_relation", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
      check("rnd_rem_lt_div", 32'(remainder < b), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
